config_sequencer: RTL and testbench
===================================

# config_sequencer

Command sequencer that sits directly downstream of the configuration command ROM. It walks ROM addresses from 0, decodes each registered command/data word, and drives a byte-wide valid/ready link to the serial shifter plus the device chip select. It pauses, delays, stops on an END command, and flags errors.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, ROM address width
- COMMAND_WIDTH, 4, command field width (minimum 4)
- DEVICE_DATA_WIDTH, 8, data field and tx byte width
- DELAY_SHIFT, 8, DELAY wait = device_data << DELAY_SHIFT cycles
- TIMEOUT_WIDTH, 12, watchdog counter width (used only with CFG_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a sequence from address 0
- rom_address  out  ADDRESS_WIDTH  registered ROM address
- controller_command  in  COMMAND_WIDTH  ROM command, valid 1 cycle after rom_address
- device_data  in  DEVICE_DATA_WIDTH  ROM data, same timing
- tx_valid  out  1  byte offered to the shifter
- tx_data  out  DEVICE_DATA_WIDTH  byte to send
- tx_ready  in  1  shifter accepts the byte
- dev_cs_n  out  1  device chip select, active low
- busy  out  1  sequence in progress
- done  out  1  sticky; END reached
- error  out  1  sticky; illegal command, address overrun, or timeout

## Operation
- Reset values: rom_address 0, tx_valid 0, tx_data 0, dev_cs_n 1, busy 0, done 0, error 0, state IDLE.
- States: IDLE, FETCH, DECODE, SEND, WAIT, HALT.
- IDLE: on start, clear done and error, set rom_address 0 and busy 1, go to FETCH.
- FETCH: one cycle covering the ROM read latency, then DECODE.
- DECODE samples controller_command:
  - 0x0 NOP: advance.
  - 0x1 WRITE: load tx_data from device_data, set tx_valid, go to SEND.
  - 0x2 CS_ASSERT: dev_cs_n 0, advance.
  - 0x3 CS_DEASSERT: dev_cs_n 1, advance.
  - 0x4 DELAY: load counter with device_data << DELAY_SHIFT. If the result is 0, advance. Otherwise go to WAIT.
  - 0xF END: done 1, busy 0, dev_cs_n 1, go to HALT.
  - Any other value: error 1, busy 0, dev_cs_n 1, go to HALT. rom_address holds the faulting address.
- Advance: if rom_address is 2^ADDRESS_WIDTH-1, set error and go to HALT. There is no wrap. Otherwise increment rom_address and go to FETCH.
- SEND: hold tx_valid and tx_data stable until a clock edge with tx_ready 1. At that edge, clear tx_valid and advance. tx_valid never depends combinationally on tx_ready.
- WAIT: decrement the counter each cycle. Advance on the cycle the counter reaches 1.
- HALT: outputs hold. start restarts exactly as from IDLE.
- start is ignored while busy is 1.
- Reset mid-operation returns every output to its reset value immediately, including a tx_valid that is high.
- Counter width is DEVICE_DATA_WIDTH+DELAY_SHIFT, so no overflow is possible.

## Timing
- start at edge N: busy 1 and rom_address 0 after edge N. FETCH in cycle N+1, DECODE in cycle N+2.
- NOP and CS commands take 2 cycles each (FETCH, DECODE).
- WRITE takes 2 cycles plus the cycles spent in SEND. With tx_ready held high, that is 3 cycles. tx_valid rises after the DECODE edge.
- DELAY with data d>0 takes 2 + (d << DELAY_SHIFT) cycles.
- END: done rises at the DECODE edge. busy falls at the same edge.
- dev_cs_n changes at the DECODE edge of its command.

## Configuration
- CFG_SEQ_TIMEOUT_EN defined:
  - A TIMEOUT_WIDTH watchdog counts the cycles spent in SEND and clears on entry to SEND.
  - If it reaches 2^TIMEOUT_WIDTH-1 with no handshake, the block sets error, drops tx_valid, sets dev_cs_n 1 and busy 0, and goes to HALT.
- CFG_SEQ_TIMEOUT_EN undefined:
  - No watchdog logic is built.
  - SEND waits for tx_ready indefinitely.

## Test plan
- ROM {0x2_00, 0x1_A5, 0x3_00, 0xF_00}, tx_ready tied 1, start pulse:
  - one transfer of 0xA5, dev_cs_n low around it;
  - done 1 exactly 9 cycles after start; busy 0; error 0.
- WRITE 0x3C with tx_ready held low for 5 cycles:
  - tx_valid and tx_data=0x3C stay stable throughout;
  - exactly one transfer occurs;
  - rom_address increments only after the handshake.
- DELAY data 0x02 with DELAY_SHIFT=8: 512 cycles in WAIT, then rom_address increments. DELAY data 0x00 takes 2 cycles total.
- Illegal command 0x7 at address 3: error 1, rom_address stays 3, no tx_valid. A following start clears error and reruns from address 0.
- ROM with no END and ADDRESS_WIDTH=4: error rises after address 15 executes, and rom_address never wraps to 0.
- Reset asserted while tx_valid=1: all outputs take their reset values without waiting for a clock edge.
- With CFG_SEQ_TIMEOUT_EN, TIMEOUT_WIDTH=4 and tx_ready stuck low: error after 15 cycles in SEND, tx_valid 0, dev_cs_n 1.

Source files
------------

// File: rtl/config_sequencer.sv
// Walks the config ROM from address 0, decoding each command into shifter bytes, chip select and delays.
// Define CFG_SEQ_TIMEOUT_EN to build the SEND watchdog (TIMEOUT_WIDTH bits); otherwise SEND waits forever.
module config_sequencer #(
  parameter int ADDRESS_WIDTH     = 8,
  parameter int COMMAND_WIDTH     = 4,
  parameter int DEVICE_DATA_WIDTH = 8,
  parameter int DELAY_SHIFT       = 8,
  parameter int TIMEOUT_WIDTH     = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [ADDRESS_WIDTH-1:0]     rom_address,
  input  logic [COMMAND_WIDTH-1:0]     controller_command,
  input  logic [DEVICE_DATA_WIDTH-1:0] device_data,
  output logic                         tx_valid,
  output logic [DEVICE_DATA_WIDTH-1:0] tx_data,
  input  logic                         tx_ready,
  output logic                         dev_cs_n,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int DLY_W = DEVICE_DATA_WIDTH + DELAY_SHIFT;

  localparam logic [COMMAND_WIDTH-1:0] CMD_NOP    = COMMAND_WIDTH'(4'h0);
  localparam logic [COMMAND_WIDTH-1:0] CMD_WRITE  = COMMAND_WIDTH'(4'h1);
  localparam logic [COMMAND_WIDTH-1:0] CMD_CS_ON  = COMMAND_WIDTH'(4'h2);
  localparam logic [COMMAND_WIDTH-1:0] CMD_CS_OFF = COMMAND_WIDTH'(4'h3);
  localparam logic [COMMAND_WIDTH-1:0] CMD_DELAY  = COMMAND_WIDTH'(4'h4);
  localparam logic [COMMAND_WIDTH-1:0] CMD_END    = COMMAND_WIDTH'(4'hF);

  if (COMMAND_WIDTH < 4 || TIMEOUT_WIDTH < 2) begin : g_param_check
    $error("config_sequencer: COMMAND_WIDTH must be >= 4 and TIMEOUT_WIDTH >= 2");
  end

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT, HALT} state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_load;
  logic             adv;
  logic             last_addr;

`ifdef CFG_SEQ_TIMEOUT_EN
  // Firing one count early means the 2^TIMEOUT_WIDTH-1'th SEND cycle is the last one.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_WIDTH-1:0] wdog;
`endif

  assign dly_load  = DLY_W'(device_data) << DELAY_SHIFT;
  assign last_addr = &rom_address;

  // Every path that moves on to the next ROM word funnels through adv.
  always_comb begin
    adv = 1'b0;
    case (state)
      DECODE: begin
        case (controller_command)
          CMD_NOP, CMD_CS_ON, CMD_CS_OFF: adv = 1'b1;
          CMD_DELAY:                      adv = (dly_load == '0);
          default:                        adv = 1'b0;
        endcase
      end
      SEND:    adv = tx_ready;
      WAIT:    adv = (dly_cnt == DLY_W'(1));
      default: adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_address <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      dev_cs_n    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      dly_cnt     <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            rom_address <= '0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          case (controller_command)
            CMD_NOP: ;
            CMD_WRITE: begin
              tx_data  <= device_data;
              tx_valid <= 1'b1;
              state    <= SEND;
`ifdef CFG_SEQ_TIMEOUT_EN
              wdog     <= '0;
`endif
            end
            CMD_CS_ON:  dev_cs_n <= 1'b0;
            CMD_CS_OFF: dev_cs_n <= 1'b1;
            CMD_DELAY: begin
              dly_cnt <= dly_load;
              if (dly_load != '0) state <= WAIT;
            end
            CMD_END: begin
              done     <= 1'b1;
              busy     <= 1'b0;
              dev_cs_n <= 1'b1;
              state    <= HALT;
            end
            default: begin
              error    <= 1'b1;
              busy     <= 1'b0;
              dev_cs_n <= 1'b1;
              state    <= HALT;
            end
          endcase
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
          end
`ifdef CFG_SEQ_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            tx_valid <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            dev_cs_n <= 1'b1;
            state    <= HALT;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        WAIT:    dly_cnt <= dly_cnt - 1'b1;
        default: state <= IDLE;
      endcase

      // Placed last so an overrun overrides whatever the command itself set.
      if (adv) begin
        if (last_addr) begin
          error    <= 1'b1;
          busy     <= 1'b0;
          dev_cs_n <= 1'b1;
          state    <= HALT;
        end else begin
          rom_address <= rom_address + 1'b1;
          state       <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Scoreboard bench for config_sequencer: directed ROM images, expected bytes queued and checked by a monitor.
module tb_config_sequencer;

  localparam int AW = 4;
  localparam int CW = 4;
  localparam int DW = 8;
  localparam int DS = 8;
  localparam int TW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          tx_ready;
  logic [AW-1:0] rom_address;
  logic [CW-1:0] cmd;
  logic [DW-1:0] ddata;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          dev_cs_n;
  logic          busy;
  logic          done;
  logic          error;

  logic [11:0] rom [16];

  typedef struct {
    logic [7:0] dat;
    logic       cs_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   tx_count = 0;
  int   n;
  logic ok;

  config_sequencer #(
    .ADDRESS_WIDTH(AW), .COMMAND_WIDTH(CW), .DEVICE_DATA_WIDTH(DW),
    .DELAY_SHIFT(DS), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_address(rom_address),
    .controller_command(cmd), .device_data(ddata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .dev_cs_n(dev_cs_n), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data appears one cycle after the address.
  always @(posedge clk) {cmd, ddata} <= rom[rom_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      tx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra got=%0h required=none", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e.dat});
        check("tx_cs_n", {31'd0, dev_cs_n}, {31'd0, e.cs_n});
      end
    end
  end

  task automatic fill_rom(input logic [11:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // what: 0 rom_address, 1 done, 2 error, 3 tx_valid. n = edges counted, -1 on timeout.
  task automatic wait_for(input int what, input int val, input int budget, output int cnt);
    int cur;
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      case (what)
        0:       cur = int'(rom_address);
        1:       cur = int'(done);
        2:       cur = int'(error);
        default: cur = int'(tx_valid);
      endcase
      if (cur == val) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  {28'd0, rom_address}, 32'd0);
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_data"},  {24'd0, tx_data}, 32'd0);
    check({tag, "_cs_n"},  {31'd0, dev_cs_n}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    fill_rom(12'h000);
    #1 reset = 1'b1;
    #3;
    check_reset_outputs("rst");
    @(posedge clk); #1 reset = 1'b0;

    // CS / WRITE / CS / END with the shifter always ready.
    fill_rom(12'h000);
    rom[0] = 12'h200; rom[1] = 12'h1A5; rom[2] = 12'h300; rom[3] = 12'hF00;
    tx_ready = 1'b1;
    tx_count = 0;
    exp_q.push_back('{dat: 8'hA5, cs_n: 1'b0});
    pulse_start;
    check("t1_busy_start", {31'd0, busy}, 32'd1);
    check("t1_addr_start", {28'd0, rom_address}, 32'd0);
    wait_for(1, 1, 50, n);
    check("t1_done_cycles", n, 9);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_cs_n_end", {31'd0, dev_cs_n}, 32'd1);
    check("t1_tx_count", tx_count, 1);

    // WRITE 0x3C stalled by tx_ready low for 5 cycles.
    fill_rom(12'h000);
    rom[0] = 12'h13C; rom[1] = 12'hF00;
    tx_ready = 1'b0;
    tx_count = 0;
    exp_q.push_back('{dat: 8'h3C, cs_n: 1'b1});
    pulse_start;
    wait_for(3, 1, 20, n);
    check("t2_valid_rise", n, 2);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h3C && rom_address === 4'd0)) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("t2_stall_stable", {31'd0, ok}, 32'd1);
    check("t2_addr_held", {28'd0, rom_address}, 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_addr_after_hs", {28'd0, rom_address}, 32'd1);
    check("t2_valid_after_hs", {31'd0, tx_valid}, 32'd0);
    wait_for(1, 1, 20, n);
    check("t2_done_cycles", n, 2);
    check("t2_tx_count", tx_count, 1);

    // DELAY 0x02 (512 cycles) then DELAY 0x00.
    fill_rom(12'h000);
    rom[0] = 12'h402; rom[1] = 12'h400; rom[2] = 12'hF00;
    tx_count = 0;
    pulse_start;
    wait_for(0, 1, 1000, n);
    check("t3_delay2_cycles", n, 514);
    wait_for(0, 2, 20, n);
    check("t3_delay0_cycles", n, 2);
    wait_for(1, 1, 20, n);
    check("t3_done_cycles", n, 2);
    check("t3_tx_count", tx_count, 0);

    // Illegal command 0x7 at address 3, then a clean rerun.
    fill_rom(12'h000);
    rom[3] = 12'h700;
    tx_ready = 1'b1;
    pulse_start;
    check("t4_done_cleared", {31'd0, done}, 32'd0);
    wait_for(2, 1, 50, n);
    check("t4_error_cycles", n, 8);
    check("t4_addr_fault", {28'd0, rom_address}, 32'd3);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_cs_n", {31'd0, dev_cs_n}, 32'd1);
    check("t4_valid", {31'd0, tx_valid}, 32'd0);
    check("t4_tx_count", tx_count, 0);
    rom[1] = 12'hF00;
    pulse_start;
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    check("t4_addr_restart", {28'd0, rom_address}, 32'd0);
    check("t4_busy_restart", {31'd0, busy}, 32'd1);
    wait_for(1, 1, 20, n);
    check("t4_rerun_done", n, 4);

    // No END anywhere: overrun after address 15, no wrap.
    fill_rom(12'h000);
    pulse_start;
    wait_for(2, 1, 100, n);
    check("t5_overrun_cycles", n, 32);
    check("t5_addr_last", {28'd0, rom_address}, 32'd15);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t5_addr_hold", {28'd0, rom_address}, 32'd15);
    check("t5_busy", {31'd0, busy}, 32'd0);

`ifdef CFG_SEQ_TIMEOUT_EN
    // Shifter never ready: watchdog fires after 15 SEND cycles.
    fill_rom(12'h000);
    rom[0] = 12'h200; rom[1] = 12'h177; rom[2] = 12'hF00;
    tx_ready = 1'b0;
    tx_count = 0;
    pulse_start;
    wait_for(3, 1, 20, n);
    check("t7_valid_rise", n, 4);
    wait_for(2, 1, 50, n);
    check("t7_timeout_cycles", n, 15);
    check("t7_valid", {31'd0, tx_valid}, 32'd0);
    check("t7_cs_n", {31'd0, dev_cs_n}, 32'd1);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_tx_count", tx_count, 0);
`endif

    // Reset mid-transfer with tx_valid high.
    fill_rom(12'h000);
    rom[0] = 12'h200; rom[1] = 12'h1AA; rom[2] = 12'hF00;
    tx_ready = 1'b0;
    pulse_start;
    wait_for(3, 1, 20, n);
    check("t6_valid_rise", n, 4);
    check("t6_cs_low", {31'd0, dev_cs_n}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    @(posedge clk); #1 reset = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
